slow_mem_mc: RTL
================

# slow_mem_mc

Parametrised multi-channel slow memory for the CHIP simulation and FPGA-prototype environment. It replaces one single-port slow memory per cache with one shared array serving N cache-line channels (I-cache, D-cache, L2, and so on). Channels are arbitrated round-robin, the access latency is programmable, and protocol errors are flagged. Each channel keeps the existing read/write/addr/wdata/rdata/ready line-transfer handshake.

## Interface
Parameters:
- N_CH, 2: number of requesting channels, 1..8.
- LINE_W, 128: line width in bits.
- AW, 28: line-address width (byte address bits [31:4]).
- DEPTH, 1024: number of lines; power of two. The array index is addr[log2(DEPTH)-1:0].
- LATENCY, 4: cycles from request sample to ready; must be 1 or more.
- LFSR_SEED, 16'hACE1: seed for random extra latency. Used only when SLOWMEM_RANDLAT_EN is defined.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  N_CH  per-channel read request.
- mem_write  in  N_CH  per-channel write request.
- mem_addr  in  N_CH*AW  per-channel line address; channel i at [i*AW +: AW].
- mem_wdata  in  N_CH*LINE_W  per-channel write data.
- mem_rdata  out  N_CH*LINE_W  per-channel read data; holds the last line returned to that channel.
- mem_ready  out  N_CH  one-cycle completion pulse per channel.
- busy  out  1  high while the FSM is not IDLE.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - Requesting channels are those with mem_read|mem_write high.
  - The round-robin arbiter grants the first requester at or after pointer `ptr`.
  - On grant: latch channel, op, addr and wdata, load the countdown with LATENCY-1 (plus extra latency when random latency is enabled), and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - Decrement the counter each cycle.
  - On the edge where the counter is 0:
    - write: array[idx] <= latched wdata.
    - read: rdata[ch] <= array[idx].
  - Then go to DONE.
- **DONE**
  - mem_ready[ch]=1 for exactly this cycle.
  - ptr <= ch+1, wrapping modulo N_CH.
  - Go to IDLE.
- Request rule: a requester holds read/write, addr and wdata stable until it sees mem_ready, and drops them by the next cycle.
  - In the first IDLE cycle after DONE, the just-served channel is masked from arbitration. This tolerates a one-cycle-late deassert.
- Request inputs are only sampled in IDLE. Changes during BUSY/DONE are ignored, and the latched values are used.
- mem_read and mem_write both high on the granted channel: treat as a write and set proto_err. proto_err is sticky until rst.
- Address bits above log2(DEPTH) are ignored, so addresses alias by wrap-around.
- The array is not reset. Its contents are preloaded by the bench ($readmemb on `mem`).

## Timing
- Reset values:
  - mem_ready=0, mem_rdata=0 (all channels), busy=0, proto_err=0.
  - FSM=IDLE, ptr=0, mask cleared, LFSR=LFSR_SEED.
- Reset mid-access aborts the access: no array write occurs and no ready pulse is issued.
- Latency:
  - A request sampled at edge E0 gives mem_ready high from edge E0+LATENCY to E0+LATENCY+1, plus any random extra.
  - Read data is valid in the same cycle as mem_ready.
  - Write data is visible to any access granted later.
- Throughput: one access per LATENCY+2 cycles at best (LATENCY in BUSY, plus DONE and IDLE).
- Simultaneous requests are served in round-robin order starting at ptr.

## Configuration
- Macro: SLOWMEM_RANDLAT_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11) advances once per grant.
  - LFSR[2:0] (0..7) is added to the countdown for that access.
  - Models a variable-latency memory for cache stress tests.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

## Structure
- Package slow_mem_pkg:
  - State enum (IDLE/BUSY/DONE).
  - Default LINE_W/AW constants.
  - LFSR tap mask and a clog2 helper constant function.
- Sub-module slow_mem_rr_arbiter:
  - Combinational priority rotate.
  - Inputs: req[N_CH], ptr, mask.
  - Outputs: gnt_valid and gnt_idx.

## Test plan
- **Single read.** N_CH=2, LATENCY=4. Preload line 5=128'h1234. Ch0 reads addr 5 at E0. Required: mem_ready[0] high only in cycle E4..E5, with rdata ch0=128'h1234.
- **Write then read.** Ch1 writes 128'hDEAD to addr 7, then ch0 reads addr 7. Required: ch0 gets 128'hDEAD; rdata ch1 stays 0.
- **Simultaneous requests.** Both channels request at the first cycle after reset. Required: ch0 is served first, then ch1. With both requests held continuously, grants alternate 0,1,0,1.
- **Protocol error and wrap-around.**
  - Ch0 raises read and write together with addr 3. Required: proto_err=1, a write is performed, and proto_err stays high.
  - Addr 1024+3 with DEPTH=1024. Required: the access hits line 3.
- **Reset mid-access.** rst during BUSY of a write to addr 9. Required: no mem_ready pulse, line 9 unchanged, all outputs return to their reset values.
- **Random latency (SLOWMEM_RANDLAT_EN defined).** 100 reads. Required: every ready arrives 4..11 cycles after its sample edge, and data is correct on every read.

Source files
------------

// File: rtl/slow_mem_pkg.sv
// slow_mem_pkg: shared state encoding, default widths, LFSR taps and clog2 helper
// for the multi-channel slow memory.
package slow_mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int LINE_W_D = 128;
   localparam int AW_D = 28;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/slow_mem_mc_if.sv
// slow_mem_mc_if: per-channel read/write/addr/wdata/rdata/ready line-transfer bus,
// all channels packed side by side.
interface slow_mem_mc_if import slow_mem_pkg::*; #(
   parameter int N_CH = 2,
   parameter int LINE_W = LINE_W_D,
   parameter int AW = AW_D
);
   logic [N_CH-1:0] mem_read, mem_write, mem_ready;
   logic [N_CH*AW-1:0] mem_addr;
   logic [N_CH*LINE_W-1:0] mem_wdata, mem_rdata;
   modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
   modport slave (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/slow_mem_rr_arbiter.sv
// slow_mem_rr_arbiter: combinational round-robin pick of the first unmasked
// requester at or after ptr.
module slow_mem_rr_arbiter import slow_mem_pkg::*; #(
   parameter int N_CH = 2,
   parameter int PW = (N_CH > 1) ? clog2(N_CH) : 1
) (
   input  logic [N_CH-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic [N_CH-1:0] mask,
   output logic            gnt_valid,
   output logic [PW-1:0]   gnt_idx
);
   logic [N_CH-1:0] live;
   logic [PW-1:0] j;
   assign live = req & ~mask;
   // Scan offsets downward so the smallest offset from ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx = '0;
      j = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % N_CH);
         if (live[j]) begin
            gnt_valid = 1'b1;
            gnt_idx = j;
         end
      end
   end
endmodule

// File: rtl/slow_mem_mc.sv
// slow_mem_mc: shared slow line memory serving N_CH channels round-robin with
// programmable latency; SLOWMEM_RANDLAT_EN adds 0..7 cycles of LFSR-driven extra latency.
module slow_mem_mc import slow_mem_pkg::*; #(
   parameter int N_CH = 2,
   parameter int LINE_W = LINE_W_D,
   parameter int AW = AW_D,
   parameter int DEPTH = 1024,
   parameter int LATENCY = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   slow_mem_mc_if.slave bus,
   output logic         busy,
   output logic         proto_err
);
   localparam int PW = (N_CH > 1) ? clog2(N_CH) : 1;
   localparam int IW = clog2(DEPTH);
   state_t state, nstate;
   logic [LINE_W-1:0] mem [DEPTH];
   logic [N_CH*LINE_W-1:0] rdata_q;
   logic [N_CH-1:0] req, mask;
   logic gnt_valid, op_wr, hit;
   logic [PW-1:0] gnt_idx, ptr, ch;
   logic [IW-1:0] idx;
   logic [LINE_W-1:0] wdata_l;
   logic [15:0] cnt, extra;

   assign req = bus.mem_read | bus.mem_write;
   assign hit = state == BUSY && cnt == '0;
   assign busy = state != IDLE;
   assign bus.mem_ready = (state == DONE) ? N_CH'(1) << ch : '0;
   assign bus.mem_rdata = rdata_q;

   slow_mem_rr_arbiter #(.N_CH(N_CH), .PW(PW)) u_arb (
      .req(req), .ptr(ptr), .mask(mask), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
   );

`ifdef SLOWMEM_RANDLAT_EN
   logic [15:0] lfsr;
   assign extra = {13'd0, lfsr[2:0]};
   always_ff @(posedge clk)
      if (rst) lfsr <= LFSR_SEED;
      else if (state == IDLE && gnt_valid) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
`else
   assign extra = '0;
`endif

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= nstate;

   always_comb nstate = state == IDLE ? (gnt_valid ? BUSY : IDLE) :
                        state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;

   // The array is never reset; a reset on the access edge suppresses the write.
   always_ff @(posedge clk)
      if (hit && op_wr && !rst) mem[idx] <= wdata_l;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         mask <= '0;
         proto_err <= 1'b0;
         cnt <= '0;
         ch <= '0;
         op_wr <= 1'b0;
         idx <= '0;
         wdata_l <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE) begin
            mask <= '0;
            if (gnt_valid) begin
               ch <= gnt_idx;
               op_wr <= bus.mem_write[gnt_idx];
               idx <= bus.mem_addr[int'(gnt_idx)*AW +: IW];
               wdata_l <= bus.mem_wdata[int'(gnt_idx)*LINE_W +: LINE_W];
               cnt <= 16'(LATENCY - 1) + extra;
               if (bus.mem_read[gnt_idx] && bus.mem_write[gnt_idx]) proto_err <= 1'b1;
            end
         end
         if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            if (hit && !op_wr) rdata_q[int'(ch)*LINE_W +: LINE_W] <= mem[idx];
         end
         // Mask the served channel for one IDLE cycle to tolerate a late deassert.
         if (state == DONE) begin
            ptr <= (int'(ch) == N_CH - 1) ? '0 : ch + 1'b1;
            mask <= N_CH'(1) << ch;
         end
      end
   end
endmodule
